// File: rtl/gpio_seg_scanner_if.sv
// Bus between the value producer and the 7-segment scanner: hex value, load strobe
// and the registered display outputs.
interface gpio_seg_scanner_if #(
    parameter int NDIG = 4
) ();
    logic [4*NDIG-1:0] value;
    logic              load;
    logic              pend;
    logic              frame_start;
    logic [6:0]        seg;
    logic [NDIG-1:0]   sel;

    modport master (output value, load, input pend, frame_start, seg, sel);
    modport slave  (input value, load, output pend, frame_start, seg, sel);
endinterface

// File: rtl/gpio_seg_scanner.sv
// Time-multiplexed, double-buffered 7-segment scanner with per-slot dead-time blanking.
// Optional leading-zero blanking is enabled by defining SCAN_LZB_EN.
module gpio_seg_scanner #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    gpio_seg_scanner_if.slave   bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    logic                r_run;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*NDIG-1:0]   r_disp;
    logic [4*NDIG-1:0]   r_pendbuf;
    logic                r_pend;
    logic                r_frame_start;
    logic [6:0]          r_seg;
    logic [NDIG-1:0]     r_sel;

    logic                w_wrap;
    logic                w_boundary;
    logic [CW-1:0]       w_cnt_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [4*NDIG-1:0]   w_disp_nxt;
    logic [3:0]          w_dig;
    logic                w_lz_blank;
    logic [6:0]          w_seg_nxt;
    logic [NDIG-1:0]     w_sel_nxt;

    // The first edge after reset release is treated as a frame boundary so that
    // cycle 0 is digit 0, cnt=0, with frame_start already asserted.
    assign w_wrap     = (r_cnt == CW'(DIV - 1));
    assign w_boundary = !r_run || (w_wrap && (r_idx == IW'(NDIG - 1)));
    assign w_cnt_nxt  = (!r_run || w_wrap) ? '0 : r_cnt + CW'(1);
    assign w_disp_nxt = (w_boundary && r_pend) ? r_pendbuf : r_disp;

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_boundary)
            w_idx_nxt = '0;
        else if (w_wrap)
            w_idx_nxt = r_idx + IW'(1);
    end

    always_comb begin
        w_dig = '0;
        for (int i = 0; i < NDIG; i++)
            if (w_idx_nxt == IW'(i))
                w_dig = w_disp_nxt[4*i +: 4];
    end

`ifdef SCAN_LZB_EN
    logic [IW-1:0] w_msd;
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NDIG; i++)
            if (w_disp_nxt[4*i +: 4] != 4'h0)
                w_msd = IW'(i);
    end
    assign w_lz_blank = (w_idx_nxt > w_msd);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Outputs are computed from next-cycle state so they line up with cnt.
    always_comb begin
        w_sel_nxt = '0;
        w_seg_nxt = '0;
        if (w_cnt_nxt >= CW'(BLANK)) begin
            w_sel_nxt = NDIG'(1) << w_idx_nxt;
            w_seg_nxt = w_lz_blank ? 7'h00 : f_decode(w_dig);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_run         <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_disp        <= '0;
            r_pendbuf     <= '0;
            r_pend        <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= '0;
            r_sel         <= '0;
        end else begin
            r_run         <= 1'b1;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_disp        <= w_disp_nxt;
            r_frame_start <= w_boundary;
            r_seg         <= w_seg_nxt;
            r_sel         <= w_sel_nxt;
            // A load on the boundary edge refills the buffer that was just emptied.
            if (bus.load) begin
                r_pendbuf <= bus.value;
                r_pend    <= 1'b1;
            end else if (w_boundary) begin
                r_pend    <= 1'b0;
            end
        end
    end

    assign bus.pend        = r_pend;
    assign bus.frame_start = r_frame_start;
    assign bus.seg         = r_seg;
    assign bus.sel         = r_sel;
endmodule

// File: tb/tb_gpio_seg_scanner.sv
// Randomized bench for gpio_seg_scanner against a cycle-indexed frame model.
module tb_gpio_seg_scanner;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_seg_scanner_if #(.NDIG(NDIG)) bus ();

    gpio_seg_scanner #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: cycle number since release and the two buffers.
    bit          m_run;
    int          m_t;
    logic [15:0] m_disp, m_pbuf;
    bit          m_pend, m_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", tag, m_t, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg();
        int c, slot, msd;
        logic [3:0] d;
        c = m_t % DIV;
        slot = (m_t / DIV) % NDIG;
        if (c < BLANK) return 7'h00;
        d = m_disp[4*slot +: 4];
        msd = 0;
        for (int i = 0; i < NDIG; i++)
            if (m_disp[4*i +: 4] != 0) msd = i;
`ifdef SCAN_LZB_EN
        if (slot > msd) return 7'h00;
`endif
        return segtab[d];
    endfunction

    function automatic logic [NDIG-1:0] exp_sel();
        int c, slot;
        c = m_t % DIV;
        slot = (m_t / DIV) % NDIG;
        if (c < BLANK) return '0;
        return NDIG'(1 << slot);
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_disp = '0; m_pbuf = '0; m_pend = 0; m_fs = 0;
    endtask

    task automatic check_all();
        chk("sel",  32'(bus.sel), 32'(exp_sel()));
        chk("seg",  32'(bus.seg), 32'(exp_seg()));
        chk("pend", 32'(bus.pend), 32'(m_pend));
        chk("fs",   32'(bus.frame_start), 32'(m_fs));
    endtask

    // Called at a negedge: drive inputs for the next edge, advance model, check.
    task automatic tick(input logic l, input logic [15:0] v);
        bus.load = l;
        bus.value = v;
        @(posedge clk);
        if (!m_run) begin m_run = 1; m_t = 0; end
        else m_t++;
        m_fs = (m_t % FRAME) == 0;
        if (m_fs && m_pend) begin m_disp = m_pbuf; m_pend = 0; end
        if (l) begin m_pbuf = v; m_pend = 1; end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0);
    endtask

    initial begin
        bus.load = 1'b0;
        bus.value = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_sel",  32'(bus.sel), 32'h0);
        chk("rst_seg",  32'(bus.seg), 32'h0);
        chk("rst_pend", 32'(bus.pend), 32'h0);
        chk("rst_fs",   32'(bus.frame_start), 32'h0);
        rst = 1'b0;

        // Idle frame, then directed loads including one on the boundary edge.
        idle(5);
        tick(1'b1, 16'h1234);
        idle(34);
        tick(1'b1, 16'hAAAA);
        idle(5);
        tick(1'b1, 16'h5555);
        idle(49);
        tick(1'b1, 16'h0007);        // edge into cycle 96: a frame boundary
        idle(53);
        tick(1'b1, 16'h0070);
        idle(80);

        // Random loads, forcing some onto boundary edges.
        for (int i = 0; i < 500; i++) begin
            logic l;
            l = ($urandom_range(0, 11) == 0) || (((m_t + 1) % FRAME == 0) && $urandom_range(0, 2) == 0);
            tick(l, 16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF));
        end

        // Reset asserted mid-DRIVE of digit 2, outputs must drop immediately.
        while ((m_t % FRAME) != 19) tick(1'b0, 16'h0);
        tick(1'b1, 16'hBEEF);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel",  32'(bus.sel), 32'h0);
        chk("arst_seg",  32'(bus.seg), 32'h0);
        chk("arst_pend", 32'(bus.pend), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(40);
        tick(1'b1, 16'hC0DE);
        idle(70);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
